// File: rtl/bsg_manycore_store_reg_id_resp_queue_if.sv
// Request-in / response-out bundle for the store reg_id response queue.
// The master side drives requests and yumi; the slave side is the queue.
interface bsg_manycore_store_reg_id_resp_queue_if #(
  parameter int data_width_p   = 32,
  parameter int reg_id_width_p = 5,
  parameter int els_p          = 4
);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic                        v_i;
  logic                        ready_o;
  logic                        is_store_i;
  logic [data_width_p-1:0]     data_i;
  logic [data_width_p/8-1:0]   mask_i;
  logic [reg_id_width_p-1:0]   load_reg_id_i;
  logic                        v_o;
  logic                        yumi_i;
  logic                        is_store_o;
  logic [reg_id_width_p-1:0]   reg_id_o;
  logic [data_width_p-1:0]     data_o;
  logic [cnt_w_lp-1:0]         count_o;

  modport master (
    output v_i, is_store_i, data_i, mask_i,
    output load_reg_id_i, yumi_i,
    input  ready_o, v_o, is_store_o,
    input  reg_id_o, data_o, count_o
  );

  modport slave (
    input  v_i, is_store_i, data_i, mask_i,
    input  load_reg_id_i, yumi_i,
    output ready_o, v_o, is_store_o,
    output reg_id_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_manycore_store_reg_id_resp_queue.sv
// Response queue recovering reg_id from masked-off store lanes or load field.
// Optional BSG_MANYCORE_RESP_QUEUE_BYPASS_EN: zero-latency path when empty.
module bsg_manycore_store_reg_id_resp_queue #(
  parameter int data_width_p   = 32,
  parameter int reg_id_width_p = 5,
  parameter int els_p          = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_store_reg_id_resp_queue_if.slave q
);
  localparam int lanes_lp = data_width_p/8;
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [ptr_w_lp-1:0]       head_r, tail_r;
  logic [cnt_w_lp-1:0]       count_r;

  logic                      st_mem  [els_p];
  logic [reg_id_width_p-1:0] rid_mem [els_p];
  logic [data_width_p-1:0]   data_mem[els_p];

  logic [reg_id_width_p-1:0] store_rid;
  logic [reg_id_width_p-1:0] in_rid;
  logic [data_width_p-1:0]   in_data;
  logic                      empty, full;
  logic                      enq, deq, bypass_take;

  // Unmasked lanes carry the reg_id; several of them are OR'd together.
  always_comb begin
    store_rid = '0;
    for (int b = 0; b < lanes_lp; b++) begin
      if (!q.mask_i[b])
        store_rid = store_rid | q.data_i[8*b +: reg_id_width_p];
    end
  end

  assign in_rid  = q.is_store_i ? store_rid : q.load_reg_id_i;
  assign in_data = q.is_store_i ? '0 : q.data_i;

  assign empty = (count_r == '0);
  assign full  = (count_r == cnt_w_lp'(els_p));

  assign q.ready_o = ~full;
  assign q.count_o = count_r;

`ifdef BSG_MANYCORE_RESP_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = empty & q.v_i;
  assign bypass_take = bypass & q.yumi_i;
  assign q.v_o        = ~empty | q.v_i;
  assign q.is_store_o = bypass ? q.is_store_i : (~empty & st_mem[head_r]);
  assign q.reg_id_o   = bypass ? in_rid
                      : (empty ? '0 : rid_mem[head_r]);
  assign q.data_o     = bypass ? in_data
                      : (empty ? '0 : data_mem[head_r]);
`else
  assign bypass_take  = 1'b0;
  assign q.v_o        = ~empty;
  assign q.is_store_o = ~empty & st_mem[head_r];
  assign q.reg_id_o   = empty ? '0 : rid_mem[head_r];
  assign q.data_o     = empty ? '0 : data_mem[head_r];
`endif

  assign enq = q.v_i & ~full & ~bypass_take;
  assign deq = q.yumi_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) tail_r <= tail_r + 1'b1;
      if (deq) head_r <= head_r + 1'b1;
      count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && enq) begin
      st_mem[tail_r]   <= q.is_store_i;
      rid_mem[tail_r]  <= in_rid;
      data_mem[tail_r] <= in_data;
    end
  end

`ifndef SYNTHESIS
  a_yumi_without_v : assert property (
    @(posedge clk_i) disable iff (reset_i) q.yumi_i |-> q.v_o
  ) else $error("yumi_i asserted while v_o is low");

  a_mask_known : assert property (
    @(posedge clk_i) disable iff (reset_i)
    (q.v_i & q.is_store_i) |-> !$isunknown(q.mask_i)
  ) else $error("mask_i unknown on store request");
`endif

endmodule

// File: tb/tb_bsg_manycore_store_reg_id_resp_queue.sv
// Scoreboard bench: driver pushes modelled entries, monitor pops on yumi.
// Random and directed traffic, checked against a byte-lane reference model.
module tb_bsg_manycore_store_reg_id_resp_queue;
  localparam int els_lp = 4;

  typedef struct {
    logic        st;
    logic [4:0]  rid;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic reset;

  bsg_manycore_store_reg_id_resp_queue_if #(
    .data_width_p(32), .reg_id_width_p(5), .els_p(els_lp)
  ) q ();

  bsg_manycore_store_reg_id_resp_queue #(
    .data_width_p(32), .reg_id_width_p(5), .els_p(els_lp)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .q      (q.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t sb[$];
  int   vectors;
  int   miscompares;
  int   cnt;
  bit   acc;
  bit   fresh;

  function automatic ent_t model(bit st, logic [31:0] d,
                                 logic [3:0] m, logic [4:0] l);
    ent_t        e;
    logic [31:0] sh;
    e.st = st;
    if (st) begin
      e.data = '0;
      e.rid  = '0;
      for (int b = 0; b < 4; b++) begin
        sh = d >> (8*b);
        if (!m[b]) e.rid = e.rid | sh[4:0];
      end
    end else begin
      e.rid  = l;
      e.data = d;
    end
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick(bit v, bit st, logic [31:0] d,
                      logic [3:0] m, logic [4:0] l, bit y);
    @(negedge clk);
    q.v_i = v;
    q.is_store_i = st;
    q.data_i = d;
    q.mask_i = m;
    q.load_reg_id_i = l;
    q.yumi_i = 1'b0;
    #1;
    q.yumi_i = y & q.v_o;
    acc = v & q.ready_o;
    if (acc) sb.push_back(model(st, d, m, l));
  endtask

  task automatic rnd(bit v, bit y);
    tick(v, 1'($urandom), $urandom, 4'($urandom),
         5'($urandom), y);
  endtask

  // Monitor: registered occupancy is sb size before this cycle's traffic.
  initial forever begin
    ent_t e;
    bit   exp_v;
    @(negedge clk);
    #2;
    if (reset) begin
      cnt = 0;
      fresh = 1'b1;
    end else begin
      chk("count_o", 32'(q.count_o), 32'(cnt));
      chk("ready_o", 32'(q.ready_o), 32'(cnt != els_lp));
`ifdef BSG_MANYCORE_RESP_QUEUE_BYPASS_EN
      exp_v = (cnt != 0) || q.v_i;
`else
      exp_v = (cnt != 0);
`endif
      chk("v_o", 32'(q.v_o), 32'(exp_v));
      if (fresh && !q.v_o) begin
        chk("idle_is_store", 32'(q.is_store_o), 32'd0);
        chk("idle_reg_id", 32'(q.reg_id_o), 32'd0);
        chk("idle_data", q.data_o, 32'd0);
      end
      if (q.v_o && q.yumi_i) begin
        if (sb.size() == 0) begin
          chk("underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("is_store_o", 32'(q.is_store_o), 32'(e.st));
          chk("reg_id_o", 32'(q.reg_id_o), 32'(e.rid));
          chk("data_o", q.data_o, e.data);
        end
      end
      if (acc) fresh = 1'b0;
      cnt = sb.size();
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    acc = 1'b0;
    reset = 1'b1;
    q.v_i = 1'b0;
    q.is_store_i = 1'b0;
    q.data_i = '0;
    q.mask_i = '0;
    q.load_reg_id_i = '0;
    q.yumi_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Store reg_id from two unmasked lanes, then full mask, then a load
    tick(1, 1, 32'h1D0E_0000, 4'b0011, 5'h00, 0);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 1);
    tick(1, 1, 32'hFFFF_FFFF, 4'b1111, 5'h00, 0);
    tick(1, 0, 32'hCAFE_F00D, 4'b0000, 5'h07, 0);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 1);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 1);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 0);

    // Fill, refused 5th, full with yumi, then accepted refill and drain
    repeat (4) rnd(1, 0);
    rnd(1, 0);
    rnd(1, 1);
    rnd(1, 0);
    repeat (4) rnd(0, 1);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 0);

    // Steady occupancy of two across pointer wrap
    repeat (2) rnd(1, 0);
    repeat (10) rnd(1, 1);
    repeat (2) rnd(0, 1);

    // Reset with entries pending; inputs during reset are ignored
    repeat (3) rnd(1, 0);
    @(negedge clk);
    reset = 1'b1;
    q.v_i = 1'b1;
    q.yumi_i = 1'b0;
    acc = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    q.v_i = 1'b0;
    tick(0, 0, 32'h0, 4'h0, 5'h00, 0);

    // Load on empty queue with yumi (bypassed when enabled)
    tick(1, 0, 32'h1234_5678, 4'h0, 5'h0B, 1);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 1);

    repeat (400) rnd(($urandom % 3) != 0, ($urandom % 3) != 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      rnd(0, 1);
    tick(0, 0, 32'h0, 4'h0, 5'h00, 0);
    chk("drain_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_store_reg_id_resp_queue.md
Name: bsg_manycore_store_reg_id_resp_queue

Overview:
- Response-side stage downstream of the endpoint's request decode.
- Accepts each serviced remote request (load or masked store) and recovers the response reg_id. For stores, the reg_id is decoded from the unused byte lanes of the store data. For loads, it comes from the packet field.
- Queues the resulting response entries and presents them in order to the return-packet launcher over a valid/yumi handshake.
- Decouples request acceptance from return-network backpressure.

Parameters:
- data_width_p, 32, request/response data width; fixed at 32 (four byte lanes).
- reg_id_width_p, bsg_manycore_reg_id_width_gp (5), response reg_id width; must be ≤ 8.
- els_p, 4, queue depth in entries; must be ≥ 2 and a power of 2.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous active-high reset.
- v_i  input  1  request entry valid.
- ready_o  output  1  queue can accept an entry this cycle.
- is_store_i  input  1  1 = store request, 0 = load request.
- data_i  input  data_width_p  store: store data carrying reg_id in masked-off lanes; load: load return data.
- mask_i  input  data_width_p/8  store byte mask (1 = byte written); ignored for loads.
- load_reg_id_i  input  reg_id_width_p  reg_id for loads; ignored for stores.
- v_o  output  1  head entry valid.
- yumi_i  input  1  consumer takes head; legal only when v_o = 1.
- is_store_o  output  1  head entry type.
- reg_id_o  output  reg_id_width_p  head entry reg_id.
- data_o  output  data_width_p  head entry data: load data for loads, all zeros for stores.
- count_o  output  $clog2(els_p+1)  current occupancy.

Behaviour:
- Enqueue occurs when v_i & ready_o.
- Store reg_id decode is combinational on the input side. It is the bitwise OR, over lanes b = 0..3 with mask_i[b] = 0, of data_i[8b +: reg_id_width_p]. Lanes with mask_i[b] = 1 contribute 0.
  - Full mask 4'b1111 gives reg_id 0.
  - Multiple unmasked lanes are OR'd, not priority-selected.
- Load entry stores load_reg_id_i and data_i unchanged.
- Store entry stores data as all zeros.
- Storage: circular buffer with head/tail pointers of $clog2(els_p) bits, wrapping from els_p-1 to 0, plus occupancy counter.
- ready_o = (count_o != els_p).
  - Depends only on registered state; no combinational path from yumi_i.
  - When full, an enqueue is refused even if yumi_i = 1 in the same cycle.
- v_o = (count_o != 0).
- Outputs are driven from the head entry register; no combinational path from v_i.
- Latency: an entry enqueued in cycle N is visible at v_o/reg_id_o in cycle N+1 at the earliest.
- Dequeue occurs when yumi_i = 1; head advances on that clock edge.
- Simultaneous enqueue and dequeue (non-empty, non-full): count unchanged, both pointers advance.
- Ordering: strict FIFO; loads and stores share one queue.
- Reset: count_o = 0, pointers = 0, v_o = 0, ready_o = 1. Entry contents are don't-care, but reg_id_o/data_o/is_store_o read as 0 while empty after reset.
- Reset asserted mid-operation discards all pending entries; inputs during reset are ignored.
- Assertions (simulation only, disabled during reset): yumi_i without v_o is an error; mask_i containing X while v_i & is_store_i is an error.

Optional Feature:
- Macro: BSG_MANYCORE_RESP_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty and v_i = 1, the input entry is presented combinationally on v_o/reg_id_o/data_o/is_store_o in the same cycle.
  - If yumi_i = 1 that cycle, the entry is consumed without being written and count stays 0.
  - If yumi_i = 0, the entry is written normally.
  - Latency is 0 cycles when empty.
- Not defined: latency is 1 cycle minimum; outputs are purely registered-state driven.

Test Plan:
- Store, mask 4'b0011, data 32'h1D0E_0000 → next cycle v_o = 1, reg_id_o = 5'h0E | 5'h1D = 5'h1F, data_o = 0, is_store_o = 1.
- Store, mask 4'b1111, data 32'hFFFF_FFFF → reg_id_o = 0. Load, load_reg_id_i = 5'h07, data 32'hCAFE_F00D → reg_id_o = 7, data_o = 32'hCAFE_F00D.
- Enqueue 4 entries with yumi_i = 0 → count_o = 4, ready_o = 0. A 5th v_i is not accepted. Then yumi_i for 4 cycles returns the entries in order, and count_o ends at 0.
- Full queue with v_i = 1 and yumi_i = 1 in the same cycle → only dequeue occurs, count_o = 3. The following cycle the enqueue is accepted.
- 10 back-to-back enqueue+dequeue cycles with occupancy 2 → pointers wrap, order preserved, count_o stays 2.
- Assert reset_i with 3 entries pending → next cycle v_o = 0, count_o = 0, ready_o = 1. With the bypass macro, a load on an empty queue with yumi_i = 1 → v_o = 1 in the same cycle and count_o remains 0.
